mac_share_ctrl: RTL

Scheduler for the shared DSP MAC bank. Arbitrates the shared DSP group (units 0–101) between the convolution layers (conv1, conv2) and fc1, and drives the bank's `sel` input. Sequences every dot-product job on all five layers (conv1, conv2, fc1, fc2, fc3): feed strobes, per-layer accumulator clear, and result-valid pulses aligned to DSP latency. Sits between the layer controllers/address generators and the MAC bank.

---
 rtl/mac_sched_pkg.sv | 33 +++
 rtl/mac_job_seq.sv | 68 ++++++
 rtl/mac_share_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_sched_pkg.sv
// Shared definitions for the MAC bank scheduler: owner FSM encoding,
// default job lengths / DSP latency, and layer index constants.
package mac_sched_pkg;

    // Owner of the shared DSP group (IDLE/CONV/FC1) or transition in progress.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        FC1   = 2'd2,
        DRAIN = 2'd3
    } owner_state_e;

    localparam int MAC_LAT_DEF   = 3;
    localparam int CONV1_LEN_DEF = 25;
    localparam int CONV2_LEN_DEF = 25;
    localparam int FC1_LEN_DEF   = 400;
    localparam int FC2_LEN_DEF   = 120;
    localparam int FC3_LEN_DEF   = 84;
    localparam int CNT_W_DEF     = 9;

    localparam int NUM_LAYERS = 5;
    localparam int L_CONV1    = 0;
    localparam int L_CONV2    = 1;
    localparam int L_FC1      = 2;
    localparam int L_FC2      = 3;
    localparam int L_FC3      = 4;

    // Width of a counter that must reach lat-1 (at least one bit).
    function automatic int drain_w(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mac_job_seq.sv
// Per-layer job sequencer: counts 0..len-1 while feeding, flags the first
// (clear/grant) and last feed cycles, and delays the last-feed flag by
// MAC_LAT cycles to produce the done pulse when the bank P output is final.
module mac_job_seq
    import mac_sched_pkg::*;
#(
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             feed,
    output logic             clr,
    output logic             last,
    output logic             done,
    output logic             busy
);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAC_LAT-1:0] dl_q, dl_d;

    assign feed = active_q;
    assign clr  = active_q && (cnt_q == '0);
    assign last = active_q && (cnt_q == (len - CNT_W'(1)));
    assign done = dl_q[MAC_LAT-1];
    assign busy = active_q | (|dl_q);

    // Job counter: a start (even on the last feed cycle) restarts at zero with no bubble.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (last) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Done delay line: the last-feed flag travels MAC_LAT stages to match the DSP pipe.
    always_comb begin
        dl_d    = '0;
        dl_d[0] = last;
        for (int i = 1; i < MAC_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    // State registers; reset drops any in-flight job and its pending done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            dl_q     <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            dl_q     <= dl_d;
        end
    end

endmodule

// File: rtl/mac_share_ctrl.sv
// Shared DSP MAC bank scheduler. Arbitrates the shared DSP group between the
// conv side (conv1+conv2, concurrent) and fc1 with round-robin on contention,
// drives the bank sel, and sequences all five layers through mac_job_seq.
// Build option: MAC_SHARE_NODRAIN_EN skips the MAC_LAT drain on a side switch.
module mac_share_ctrl
    import mac_sched_pkg::*;
#(
    parameter int MAC_LAT   = MAC_LAT_DEF,
    parameter int CONV1_LEN = CONV1_LEN_DEF,
    parameter int CONV2_LEN = CONV2_LEN_DEF,
    parameter int FC1_LEN   = FC1_LEN_DEF,
    parameter int FC2_LEN   = FC2_LEN_DEF,
    parameter int FC3_LEN   = FC3_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic conv1_req,
    input  logic conv2_req,
    input  logic fc1_req,
    input  logic fc2_req,
    input  logic fc3_req,
    output logic conv1_gnt,
    output logic conv2_gnt,
    output logic fc1_gnt,
    output logic fc2_gnt,
    output logic fc3_gnt,
    output logic conv1_feed,
    output logic conv2_feed,
    output logic fc1_feed,
    output logic fc2_feed,
    output logic fc3_feed,
    output logic conv1_clr,
    output logic conv2_clr,
    output logic fc1_clr,
    output logic fc2_clr,
    output logic fc3_clr,
    output logic conv1_done,
    output logic conv2_done,
    output logic fc1_done,
    output logic fc2_done,
    output logic fc3_done,
    output logic sel,
    output logic busy
);

    localparam int DRW = drain_w(MAC_LAT);

    logic [NUM_LAYERS-1:0] req_v, start_v, feed_v, clr_v, last_v, done_v, busy_v;
    logic [CNT_W-1:0]      len_v [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] free_v;

    owner_state_e   state_q, state_d;
    logic           sel_q, sel_d;
    logic [DRW-1:0] drain_cnt_q, drain_cnt_d;

    logic conv_req, fc1_wait, conv_cont, fc1_cont, do_switch;

    assign req_v = {fc3_req, fc2_req, fc1_req, conv2_req, conv1_req};

    assign len_v[L_CONV1] = CNT_W'(CONV1_LEN);
    assign len_v[L_CONV2] = CNT_W'(CONV2_LEN);
    assign len_v[L_FC1]   = CNT_W'(FC1_LEN);
    assign len_v[L_FC2]   = CNT_W'(FC2_LEN);
    assign len_v[L_FC3]   = CNT_W'(FC3_LEN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_seq
            mac_job_seq #(
                .MAC_LAT (MAC_LAT),
                .CNT_W   (CNT_W)
            ) u_seq (
                .clk   (clk),
                .rst_n (rst_n),
                .start (start_v[gi]),
                .len   (len_v[gi]),
                .feed  (feed_v[gi]),
                .clr   (clr_v[gi]),
                .last  (last_v[gi]),
                .done  (done_v[gi]),
                .busy  (busy_v[gi])
            );
        end
    endgenerate

    // A layer can take a new job next cycle when idle or on its final feed cycle.
    assign free_v = ~feed_v | last_v;

    assign conv_req  = req_v[L_CONV1] | req_v[L_CONV2];
    assign fc1_wait  = req_v[L_FC1];
    // A job on that side is still feeding after this cycle.
    assign conv_cont = (feed_v[L_CONV1] & ~last_v[L_CONV1]) |
                       (feed_v[L_CONV2] & ~last_v[L_CONV2]);
    assign fc1_cont  = feed_v[L_FC1] & ~last_v[L_FC1];

    // Owner FSM next state, grant decisions and sel; fc2/fc3 are never arbitrated.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        drain_cnt_d = drain_cnt_q;
        do_switch   = 1'b0;
        start_v     = '0;
        start_v[L_FC2] = req_v[L_FC2] & free_v[L_FC2];
        start_v[L_FC3] = req_v[L_FC3] & free_v[L_FC3];

        case (state_q)
            IDLE: begin
                if (sel_q) begin
                    if (conv_req) begin
                        start_v[L_CONV1] = req_v[L_CONV1] & free_v[L_CONV1];
                        start_v[L_CONV2] = req_v[L_CONV2] & free_v[L_CONV2];
                        state_d = CONV;
                    end else if (fc1_wait) begin
                        do_switch = 1'b1;
                    end
                end else begin
                    if (fc1_wait) begin
                        start_v[L_FC1] = free_v[L_FC1];
                        state_d = FC1;
                    end else if (conv_req) begin
                        do_switch = 1'b1;
                    end
                end
            end
            CONV: begin
                // fc1 waiting: no new conv grants, hand over once conv feeding ends.
                if (fc1_wait) begin
                    if (!conv_cont) do_switch = 1'b1;
                end else begin
                    start_v[L_CONV1] = req_v[L_CONV1] & free_v[L_CONV1];
                    start_v[L_CONV2] = req_v[L_CONV2] & free_v[L_CONV2];
                    if (!conv_cont && !start_v[L_CONV1] && !start_v[L_CONV2])
                        state_d = IDLE;
                end
            end
            FC1: begin
                if (conv_req) begin
                    if (!fc1_cont) do_switch = 1'b1;
                end else begin
                    start_v[L_FC1] = fc1_wait & free_v[L_FC1];
                    if (!fc1_cont && !start_v[L_FC1])
                        state_d = IDLE;
                end
            end
            DRAIN: begin
                // sel already points at the new owner; grant it on the last drain cycle.
                if (drain_cnt_q == DRW'(MAC_LAT - 1)) begin
                    if (sel_q && conv_req) begin
                        start_v[L_CONV1] = req_v[L_CONV1];
                        start_v[L_CONV2] = req_v[L_CONV2];
                        state_d = CONV;
                    end else if (!sel_q && fc1_wait) begin
                        start_v[L_FC1] = 1'b1;
                        state_d = FC1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + DRW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_switch) begin
            sel_d = ~sel_q;
`ifdef MAC_SHARE_NODRAIN_EN
            state_d = sel_q ? FC1 : CONV;
`else
            state_d     = DRAIN;
            drain_cnt_d = '0;
`endif
        end
    end

    // Owner FSM registers; sel resets to conv ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b1;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign sel  = sel_q;
    assign busy = |busy_v;

    assign conv1_gnt  = clr_v[L_CONV1];
    assign conv2_gnt  = clr_v[L_CONV2];
    assign fc1_gnt    = clr_v[L_FC1];
    assign fc2_gnt    = clr_v[L_FC2];
    assign fc3_gnt    = clr_v[L_FC3];
    assign conv1_clr  = clr_v[L_CONV1];
    assign conv2_clr  = clr_v[L_CONV2];
    assign fc1_clr    = clr_v[L_FC1];
    assign fc2_clr    = clr_v[L_FC2];
    assign fc3_clr    = clr_v[L_FC3];
    assign conv1_feed = feed_v[L_CONV1];
    assign conv2_feed = feed_v[L_CONV2];
    assign fc1_feed   = feed_v[L_FC1];
    assign fc2_feed   = feed_v[L_FC2];
    assign fc3_feed   = feed_v[L_FC3];
    assign conv1_done = done_v[L_CONV1];
    assign conv2_done = done_v[L_CONV2];
    assign fc1_done   = done_v[L_FC1];
    assign fc2_done   = done_v[L_FC2];
    assign fc3_done   = done_v[L_FC3];

endmodule
